matmul_relu_seq: RTL and testbench

Parametrised, sequential successor to the team's fully combinational 10x20 by 20x10 matrix-multiply/bias/ReLU block. It computes Result = post(A x B, bias) for an MxK image and a KxN weight matrix using a single MAC unit over multiple cycles. A valid/ready handshake sits on both input and output, ReLU is selectable at run time, and the block counts clipped elements. It sits between the feature-map buffer and the next layer stage.

---
 rtl/matmul_relu_seq.sv | 99 +++++++++
 tb/tb_matmul_relu_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_relu_seq.sv
// matmul_relu_seq: single-MAC sequential A(MxK) x B(KxN) + bias with optional ReLU.
// Elements are produced in row-major order, taking K+1 cycles each.
module matmul_relu_seq #(
  parameter int M  = 10,
  parameter int K  = 20,
  parameter int N  = 10,
  parameter int DW = 30,
  parameter int CW = $clog2(M*N+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [M*K*DW-1:0] image,
  input  logic [K*N*DW-1:0] weight,
  input  logic [N*DW-1:0]   bias,
  input  logic              relu_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [M*N*DW-1:0] result,
  output logic [CW-1:0]     clip_cnt
);
  localparam int IW = $clog2(M+1);
  localparam int JW = $clog2(N+1);
  localparam int KW = $clog2(K+1);
  localparam logic [IW-1:0] IL = IW'(M-1);
  localparam logic [JW-1:0] JL = JW'(N-1);
  localparam logic [KW-1:0] KL = KW'(K-1);
  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;
  state_t              r_state;
  logic [M*K*DW-1:0]   r_img;
  logic [K*N*DW-1:0]   r_wt;
  logic [N*DW-1:0]     r_bias;
  logic                r_relu;
  logic [DW-1:0]       r_acc;
  logic [IW-1:0]       r_i;
  logic [JW-1:0]       r_j;
  logic [KW-1:0]       r_k;
  logic [DW-1:0]       w_a, w_b, w_bj, w_prod;
  logic                w_last, w_clip;
  int                  w_ridx;
  // element [0][0] sits at the MSB of every flat bus
  assign w_a    = r_img[(M*K-1-(int'(r_i)*K+int'(r_k)))*DW +: DW];
  assign w_b    = r_wt[(K*N-1-(int'(r_k)*N+int'(r_j)))*DW +: DW];
  assign w_bj   = r_bias[(N-1-int'(r_j))*DW +: DW];
  assign w_ridx = (M*N-1-(int'(r_i)*N+int'(r_j)))*DW;
  assign w_prod = w_a * w_b;
  assign w_last = (r_i == IL) && (r_j == JL);
  assign w_clip = r_relu && r_acc[DW-1];
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_img    <= '0;
      r_wt     <= '0;
      r_bias   <= '0;
      r_relu   <= 1'b0;
      r_acc    <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      result   <= '0;
      clip_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_img    <= image;
          r_wt     <= weight;
          r_bias   <= bias;
          r_relu   <= relu_en;
          r_acc    <= '0;
          r_i      <= '0;
          r_j      <= '0;
          r_k      <= '0;
          clip_cnt <= '0;
          r_state  <= CALC;
        end
        CALC: begin
          r_acc <= r_acc + w_prod;
          r_k   <= r_k + KW'(1);
          if (r_k == KL) r_state <= FIN;
        end
        FIN: begin
          // the ReLU decision uses the sum before the bias is added
          result[w_ridx +: DW] <= w_clip ? '0 : r_acc + w_bj;
          if (w_clip) clip_cnt <= clip_cnt + CW'(1);
          r_acc   <= '0;
          r_k     <= '0;
          r_j     <= (r_j == JL) ? '0 : r_j + JW'(1);
          r_i     <= (r_j == JL) ? r_i + IW'(1) : r_i;
          r_state <= w_last ? DONE : CALC;
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_relu_seq.sv
// tb_matmul_relu_seq: randomized and directed jobs on default and 2x3x2/8-bit instances
// checked against an arithmetic matrix model.
module tb_matmul_relu_seq;
  localparam int M = 10, K = 20, N = 10, DW = 30;
  localparam int SM = 2, SK = 3, SN = 2, SDW = 8;
  localparam longint unsigned MASK = (64'd1 << DW) - 1;
  localparam longint unsigned SMASK = (64'd1 << SDW) - 1;
  logic clk, rst_n;
  logic in_valid, in_ready, relu_en, out_valid, out_ready;
  logic [M*K*DW-1:0] image;
  logic [K*N*DW-1:0] weight;
  logic [N*DW-1:0]   bias;
  logic [M*N*DW-1:0] result;
  logic [6:0]        clip_cnt;
  logic s_iv, s_ir, s_relu, s_ov, s_or;
  logic [SM*SK*SDW-1:0] s_img;
  logic [SK*SN*SDW-1:0] s_wt;
  logic [SN*SDW-1:0]    s_bs;
  logic [SM*SN*SDW-1:0] s_res;
  logic [2:0]           s_clip;
  logic [DW-1:0]  a [M][K];
  logic [DW-1:0]  b [K][N];
  logic [DW-1:0]  bv [N];
  logic [DW-1:0]  e [M][N];
  int             e_clip;
  logic [SDW-1:0] sa [SM][SK];
  logic [SDW-1:0] sb [SK][SN];
  logic [SDW-1:0] sbv [SN];
  logic [SDW-1:0] se [SM][SN];
  int             se_clip;
  int n_chk = 0, n_fail = 0;
  matmul_relu_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .image(image), .weight(weight), .bias(bias), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .clip_cnt(clip_cnt)
  );
  matmul_relu_seq #(.M(SM), .K(SK), .N(SN), .DW(SDW)) sdut (
    .clk(clk), .rst_n(rst_n), .in_valid(s_iv), .in_ready(s_ir),
    .image(s_img), .weight(s_wt), .bias(s_bs), .relu_en(s_relu),
    .out_valid(s_ov), .out_ready(s_or), .result(s_res), .clip_cnt(s_clip)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] res_at(int r, int j);
    return result[(M*N-1-(r*N+j))*DW +: DW];
  endfunction
  task automatic clear_mats();
    foreach (a[r, c]) a[r][c] = '0;
    foreach (b[r, c]) b[r][c] = '0;
    foreach (bv[j]) bv[j] = '0;
  endtask
  task automatic rand_mats();
    foreach (a[r, c]) a[r][c] = DW'($urandom());
    foreach (b[r, c]) b[r][c] = DW'($urandom());
    foreach (bv[j]) bv[j] = DW'($urandom());
    relu_en = 1'($urandom());
  endtask
  task automatic pack_and_model();
    longint unsigned s;
    foreach (a[r, c]) image[(M*K-1-(r*K+c))*DW +: DW] = a[r][c];
    foreach (b[r, c]) weight[(K*N-1-(r*N+c))*DW +: DW] = b[r][c];
    foreach (bv[j]) bias[(N-1-j)*DW +: DW] = bv[j];
    e_clip = 0;
    for (int r = 0; r < M; r++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < K; k++) s = (s + ((longint'(a[r][k]) * longint'(b[k][j])) & MASK)) & MASK;
        if (relu_en && s >= (64'd1 << (DW-1))) begin
          e[r][j] = '0;
          e_clip++;
        end else e[r][j] = DW'((s + bv[j]) & MASK);
      end
  endtask
  task automatic run_job(input string nm, input int hold);
    int lat;
    pack_and_model();
    check({nm, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 3000);
    check({nm, "_latency"}, lat, M*N*(K+1));
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'($urandom());
      image[63:0] = {$urandom(), $urandom()};
      weight[31:0] = $urandom();
      bias[31:0] = $urandom();
      relu_en = ~relu_en;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (hold > 0) begin
      check({nm, "_hold_in_ready"}, in_ready, 0);
      check({nm, "_hold_out_valid"}, out_valid, 1);
    end
    for (int r = 0; r < M; r++)
      for (int j = 0; j < N; j++)
        check($sformatf("%s_res[%0d][%0d]", nm, r, j), res_at(r, j), e[r][j]);
    check({nm, "_clip"}, clip_cnt, e_clip);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, "_idle_ready"}, in_ready, 1);
    check({nm, "_idle_valid"}, out_valid, 0);
  endtask
  task automatic scen1();
    clear_mats();
    foreach (a[r, c]) a[r][c] = 1;
    foreach (b[r, c]) b[r][c] = 1;
    foreach (bv[j]) bv[j] = DW'(j);
    relu_en = 1'b1;
  endtask
  task automatic run_small(input string nm);
    longint unsigned s;
    int lat;
    foreach (sa[r, c]) s_img[(SM*SK-1-(r*SK+c))*SDW +: SDW] = sa[r][c];
    foreach (sb[r, c]) s_wt[(SK*SN-1-(r*SN+c))*SDW +: SDW] = sb[r][c];
    foreach (sbv[j]) s_bs[(SN-1-j)*SDW +: SDW] = sbv[j];
    se_clip = 0;
    for (int r = 0; r < SM; r++)
      for (int j = 0; j < SN; j++) begin
        s = 0;
        for (int k = 0; k < SK; k++) s = (s + sa[r][k] * sb[k][j]) & SMASK;
        if (s_relu && s >= 128) begin
          se[r][j] = '0;
          se_clip++;
        end else se[r][j] = SDW'((s + sbv[j]) & SMASK);
      end
    s_iv = 1'b1;
    @(posedge clk); #1;
    s_iv = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!s_ov && lat < 100);
    check({nm, "_latency"}, lat, 16);
    for (int r = 0; r < SM; r++)
      for (int j = 0; j < SN; j++)
        check($sformatf("%s_res[%0d][%0d]", nm, r, j), s_res[(SM*SN-1-(r*SN+j))*SDW +: SDW], se[r][j]);
    check({nm, "_clip"}, s_clip, se_clip);
    s_or = 1'b1;
    @(posedge clk); #1;
    s_or = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; relu_en = 1'b0;
    image = '0; weight = '0; bias = '0;
    s_iv = 1'b0; s_or = 1'b0; s_relu = 1'b0; s_img = '0; s_wt = '0; s_bs = '0;
    #12;
    check("rst_result", |result, 0);
    check("rst_clip", clip_cnt, 0);
    check("rst_out_valid", out_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);
    scen1();
    run_job("s1", 0);
    check("s1_00_const", res_at(0, 0), 20);
    check("s1_99_const", res_at(9, 9), 29);
    clear_mats();
    a[0][0] = DW'(1 << 29);
    foreach (bv[j]) begin b[0][j] = 1; bv[j] = 5; end
    relu_en = 1'b1;
    run_job("s2_relu", 0);
    check("s2_clip_const", clip_cnt, 10);
    relu_en = 1'b0;
    run_job("s2_norelu", 0);
    check("s2_00_const", res_at(0, 0), (1 << 29) + 5);
    clear_mats();
    a[0][0] = DW'(1 << 15); b[0][0] = DW'(1 << 15); bv[0] = 7; relu_en = 1'b1;
    run_job("s3_prod_wrap", 0);
    check("s3_00_const", res_at(0, 0), 7);
    clear_mats();
    a[0][0] = DW'(1 << 29); a[0][1] = DW'(1 << 29); b[0][0] = 1; b[1][0] = 1; relu_en = 1'b0;
    run_job("s3_sum_wrap", 0);
    check("s3b_00_const", res_at(0, 0), 0);
    rand_mats();
    run_job("s4_hold", 50);
    rand_mats();
    run_job("s4_next", 0);
    rand_mats();
    pack_and_model();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (1000) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("s5_rst_result", |result, 0);
    check("s5_rst_clip", clip_cnt, 0);
    check("s5_rst_out_valid", out_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    scen1();
    run_job("s5_after", 0);
    for (int t = 0; t < 3; t++) begin
      rand_mats();
      run_job($sformatf("rand%0d", t), 0);
    end
    sa[0][0] = 1; sa[0][1] = 2; sa[0][2] = 3; sa[1][0] = 4; sa[1][1] = 5; sa[1][2] = 6;
    sb[0][0] = 1; sb[0][1] = 0; sb[1][0] = 0; sb[1][1] = 1; sb[2][0] = 1; sb[2][1] = 1;
    sbv[0] = 10; sbv[1] = 0; s_relu = 1'b1;
    run_small("s6");
    check("s6_00_const", s_res[31:24], 14);
    check("s6_11_const", s_res[7:0], 11);
    for (int t = 0; t < 4; t++) begin
      foreach (sa[r, c]) sa[r][c] = SDW'($urandom());
      foreach (sb[r, c]) sb[r][c] = SDW'($urandom());
      foreach (sbv[j]) sbv[j] = SDW'($urandom());
      s_relu = 1'($urandom());
      run_small($sformatf("srand%0d", t));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
